psum_accum: RTL
===============

PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 The block SHALL have parameter col, default 8, meaning number of psum columns.
REQ-002 The block SHALL have parameter psum_bw, default 16, meaning signed psum width per column.
REQ-003 The block SHALL have parameter addr_bw, default 4, meaning buffer depth of 2**addr_bw entries.
REQ-004 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid  input  1  write request from the corelet OFIFO.
REQ-007 The block SHALL have port in_ready  output  1  write accepted this cycle.
REQ-008 The block SHALL have port in_data  input  col*psum_bw  packed psums, column 0 in the LSBs.
REQ-009 The block SHALL have port in_addr  input  addr_bw  target entry.
REQ-010 The block SHALL have port in_acc  input  1  1 = accumulate, 0 = overwrite.
REQ-011 The block SHALL have port rd_valid  input  1  readout request.
REQ-012 The block SHALL have port rd_ready  output  1  readout request accepted this cycle.
REQ-013 The block SHALL have port rd_addr  input  addr_bw  readout entry.
REQ-014 The block SHALL have port rd_clr  input  1  zero the entry after it is read.
REQ-015 The block SHALL have port out_valid  output  1  out_data holds a result.
REQ-016 The block SHALL have port out_ready  input  1  downstream takes the result.
REQ-017 The block SHALL have port out_data  output  col*psum_bw  readout result.
REQ-018 The block SHALL have port ovf  output  col  sticky per-column saturation flags.

Function
REQ-019 The block SHALL assert in_ready whenever reset is high; a write SHALL occur on a clk edge with in_valid and in_ready both high.
REQ-020 An overwrite SHALL store in_data; an accumulate SHALL store the per-column signed sum of the entry and in_data.
REQ-021 Each column sum SHALL saturate to +(2**(psum_bw-1))-1 or -(2**(psum_bw-1)), and SHALL set the matching ovf bit on saturation.
REQ-022 rd_ready SHALL equal (!out_valid || out_ready); a read SHALL be accepted when rd_valid and rd_ready are both high.
REQ-023 An accepted read SHALL load out_data on the next edge and set out_valid; read latency is 1 cycle.
REQ-024 out_valid and out_data SHALL stay stable until out_ready is high; back-to-back reads SHALL sustain 1 result per cycle.
REQ-025 If no new read is accepted, out_valid SHALL clear on the edge where out_ready is high.
REQ-026 Same-cycle write and read to the same address SHALL return the post-write value (forwarded).
REQ-027 An accepted read with rd_clr SHALL zero the entry; if a write hits the same entry that cycle, the entry SHALL be in_data (accumulate against zero).
REQ-028 Writes and reads to different addresses SHALL proceed independently in the same cycle.
REQ-029 Address wrap SHALL not apply; every in_addr/rd_addr value is a valid entry.

Reset
REQ-030 While reset is low, in_ready=0, out_valid=0, out_data=0, ovf=0, and all entries SHALL be 0.
REQ-031 Reset mid-operation SHALL discard any pending result and in-flight write without producing out_valid.

Configuration
REQ-032 With PSUM_ACCUM_RELU_EN defined, readout SHALL clamp negative columns to 0 in out_data (stored entry unchanged).
REQ-033 Without PSUM_ACCUM_RELU_EN, out_data SHALL be the raw signed entry.

Verification
REQ-034 Overwrite entry 3 with all columns 5, then accumulate with 7; read entry 3 -> every column 12, one cycle after acceptance.
REQ-035 Accumulate 32767 + 1 in column 0 (psum_bw=16) -> column 0 reads 32767, ovf[0]=1 and stays 1 until reset.
REQ-036 Hold out_ready=0 for 3 cycles with rd_valid high -> rd_ready=0, out_data unchanged; release -> next result the following cycle.
REQ-037 Same cycle: write entry 2 with 9 (overwrite), read entry 2 with rd_clr -> out_data=9; entry 2 then holds 9, not 0.
REQ-038 Entry holds -4 in column 1: read -> out_data column 1 is 0 with PSUM_ACCUM_RELU_EN defined, and -4 without it.
REQ-039 Pull reset low while out_valid=1 -> out_valid=0 and ovf=0 immediately; a read after reset release -> 0.

Source files
------------

// File: rtl/psum_accum.sv
// psum_accum: partial-sum accumulation buffer for a corelet output path.
// Each entry holds `col` signed psums of `psum_bw` bits. A write either
// overwrites an entry or adds into it with per-column saturation, which
// sets a sticky overflow flag for that column. Reads have 1-cycle latency
// behind a valid/ready output stage. A read can optionally clear its entry.
// A same-cycle write to the entry being read is forwarded to the read.
// Optional feature: define PSUM_ACCUM_RELU_EN to clamp negative columns to
// zero on readout. The stored entry is not changed by this clamp.
module psum_accum #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [col*psum_bw-1:0]   in_data,
  input  logic [addr_bw-1:0]       in_addr,
  input  logic                     in_acc,
  input  logic                     rd_valid,
  output logic                     rd_ready,
  input  logic [addr_bw-1:0]       rd_addr,
  input  logic                     rd_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [col*psum_bw-1:0]   out_data,
  output logic [col-1:0]           ovf
);

  localparam int depth   = 1 << addr_bw;
  localparam int data_bw = col * psum_bw;

  logic [data_bw-1:0] mem [depth];

  logic               wr_fire;
  logic               rd_fire;
  logic               same_addr;
  logic               clr_hit;
  logic [data_bw-1:0] wr_base;
  logic [data_bw-1:0] wr_result;
  logic [col-1:0]     wr_sat;
  logic [data_bw-1:0] rd_value;

  // Signed add of one column with saturation; the MSB of the result is the
  // saturation flag and the remaining bits are the clamped sum.
  function automatic logic [psum_bw:0] sat_add(input logic [psum_bw-1:0] a,
                                                input logic [psum_bw-1:0] b);
    logic [psum_bw:0]   s;
    logic [psum_bw-1:0] r;
    logic               o;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    o = s[psum_bw] ^ s[psum_bw-1];
    if (!o) begin
      r = s[psum_bw-1:0];
    end else if (s[psum_bw]) begin
      r = {1'b1, {(psum_bw-1){1'b0}}};
    end else begin
      r = {1'b0, {(psum_bw-1){1'b1}}};
    end
    return {o, r};
  endfunction

`ifdef PSUM_ACCUM_RELU_EN
  // Readout shaping: negative columns become zero.
  function automatic logic [data_bw-1:0] shape_out(input logic [data_bw-1:0] v);
    logic [data_bw-1:0] r;
    r = v;
    for (int c = 0; c < col; c++) begin
      if (v[c*psum_bw + psum_bw - 1]) begin
        r[c*psum_bw +: psum_bw] = {psum_bw{1'b0}};
      end else begin
        r[c*psum_bw +: psum_bw] = v[c*psum_bw +: psum_bw];
      end
    end
    return r;
  endfunction
`else
  // Readout shaping: raw signed entry.
  function automatic logic [data_bw-1:0] shape_out(input logic [data_bw-1:0] v);
    return v;
  endfunction
`endif

  // The write port is always open outside reset. While reset is low every
  // register is held cleared, so the write strobe needs no reset term and
  // the reset net stays a pure asynchronous reset inside the block.
  assign in_ready  = reset;
  assign wr_fire   = in_valid;
  assign rd_ready  = !out_valid || out_ready;
  assign rd_fire   = rd_valid && rd_ready;
  assign same_addr = (in_addr == rd_addr);
  assign clr_hit   = wr_fire && rd_fire && rd_clr && same_addr;

  // Per-column write result: saturating sum against the entry, or against
  // zero for an overwrite, which can never saturate.
  always_comb begin
    wr_base   = {data_bw{1'b0}};
    wr_result = {data_bw{1'b0}};
    wr_sat    = {col{1'b0}};
    if (in_acc) begin
      wr_base = mem[in_addr];
    end else begin
      wr_base = {data_bw{1'b0}};
    end
    for (int c = 0; c < col; c++) begin
      {wr_sat[c], wr_result[c*psum_bw +: psum_bw]} =
        sat_add(wr_base[c*psum_bw +: psum_bw], in_data[c*psum_bw +: psum_bw]);
    end
  end

  // Read source: forward the post-write value when the write hits the same entry.
  always_comb begin
    rd_value = {data_bw{1'b0}};
    if (wr_fire && same_addr) begin
      rd_value = wr_result;
    end else begin
      rd_value = mem[rd_addr];
    end
  end

  // Entry storage. A clearing read zeroes its entry. A write to that same
  // entry in the same cycle lands on the zeroed entry, so it stores in_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        mem[i] <= {data_bw{1'b0}};
      end
    end else begin
      if (rd_fire && rd_clr) begin
        mem[rd_addr] <= {data_bw{1'b0}};
      end
      if (wr_fire) begin
        if (clr_hit) begin
          mem[in_addr] <= in_data;
        end else begin
          mem[in_addr] <= wr_result;
        end
      end
    end
  end

  // Output stage: load on an accepted read, drop valid once the result is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= {data_bw{1'b0}};
    end else if (rd_fire) begin
      out_valid <= 1'b1;
      out_data  <= shape_out(rd_value);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky per-column saturation flags; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= {col{1'b0}};
    end else if (wr_fire) begin
      ovf <= ovf | wr_sat;
    end
  end

endmodule
